// File: rtl/id_stage_if.sv
// id_stage_if: decode-stage bus bundling upstream fetch, regfile read, flush and downstream EX signals
//   master: environment side (fetch, regfile, EX); slave: id_stage itself
interface id_stage_if #(parameter int PC_WIDTH = 10);
  logic                in_valid;
  logic                in_ready;
  logic [PC_WIDTH-1:0] pc_i;
  logic [31:0]         inst;
  logic                rs1_re;
  logic                rs2_re;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic [31:0]         rs1_data_i;
  logic [31:0]         rs2_data_i;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [31:0]         out_imm;
  logic [31:0]         out_rs1_data;
  logic [31:0]         out_rs2_data;
  logic                out_rd_we;
  logic [4:0]          out_rd_addr;
  logic                out_is_load;
  logic                out_illegal;
  modport master (
    output in_valid, pc_i, inst, rs1_data_i, rs2_data_i, flush, out_ready,
    input  in_ready, rs1_re, rs2_re, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode,
           out_funct3, out_funct7, out_imm, out_rs1_data, out_rs2_data, out_rd_we,
           out_rd_addr, out_is_load, out_illegal
  );
  modport slave (
    input  in_valid, pc_i, inst, rs1_data_i, rs2_data_i, flush, out_ready,
    output in_ready, rs1_re, rs2_re, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode,
           out_funct3, out_funct7, out_imm, out_rs1_data, out_rs2_data, out_rd_we,
           out_rd_addr, out_is_load, out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with regfile read, load-use stall and a one-entry registered output
//   clk, rst (async active-low); bus: id_stage_if.slave carrying fetch handshake (in_valid/in_ready,
//   pc_i, inst), regfile read (rs*_re/addr/data_i), flush, and registered EX outputs (out_*)
module id_stage #(
  parameter int PC_WIDTH  = 10,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  state_t      state_q;
  logic [31:0] ins;
  logic [6:0]  opc;
  logic        i31;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_load, is_opimm, is_branch, is_store, is_op;
  logic        rd_en, illegal, shamt, hazard, accept;
  logic [4:0]  rd;
  logic [31:0] imm;
  assign ins       = bus.inst;
  assign opc       = ins[6:0];
  assign i31       = ins[31];
  assign is_lui    = opc == OP_LUI;
  assign is_auipc  = opc == OP_AUIPC;
  assign is_jal    = opc == OP_JAL;
  assign is_jalr   = opc == OP_JALR;
  assign is_load   = opc == OP_LOAD;
  assign is_opimm  = opc == OP_IMM;
  assign is_branch = opc == OP_BRANCH;
  assign is_store  = opc == OP_STORE;
  assign is_op     = opc == OP_OP;
  assign bus.rs1_re = is_jalr | is_load | is_opimm | is_branch | is_store | is_op;
  assign bus.rs2_re = is_branch | is_store | is_op;
  assign rd_en      = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;
  assign illegal    = !(bus.rs1_re | rd_en);
  assign bus.rs1_addr = bus.rs1_re ? ins[19:15] : 5'd0;
  assign bus.rs2_addr = bus.rs2_re ? ins[24:20] : 5'd0;
  assign rd           = rd_en ? ins[11:7] : 5'd0;
  // SLLI/SRLI/SRAI (funct3 001/101) carry an unsigned shift amount instead of a signed immediate
  assign shamt = is_opimm & (ins[13:12] == 2'b01);
  always_comb
    imm = shamt                         ? {27'd0, ins[24:20]} :
          (is_jalr | is_load | is_opimm) ? {{20{i31}}, ins[31:20]} :
          is_store                       ? {{20{i31}}, ins[31:25], ins[11:7]} :
          is_branch                      ? {{19{i31}}, i31, ins[7], ins[30:25], ins[11:8], 1'b0} :
          (is_lui | is_auipc)            ? {ins[31:12], 12'd0} :
          is_jal                         ? {{11{i31}}, i31, ins[19:12], ins[20], ins[30:21], 1'b0} :
                                           32'd0;
  // load-use: the held load writes a register the incoming instruction reads this cycle
  assign hazard = HAZARD_EN & bus.out_valid & bus.out_is_load & bus.out_rd_we & bus.in_valid &
                  ((bus.rs1_re & (bus.rs1_addr == bus.out_rd_addr)) |
                   (bus.rs2_re & (bus.rs2_addr == bus.out_rd_addr)));
  assign bus.in_ready = !bus.flush & !hazard & (!bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= EMPTY;
      bus.out_valid    <= 1'b0;
      bus.out_pc       <= {PC_WIDTH{1'b0}};
      bus.out_opcode   <= '0;
      bus.out_funct3   <= '0;
      bus.out_funct7   <= '0;
      bus.out_imm      <= '0;
      bus.out_rs1_data <= '0;
      bus.out_rs2_data <= '0;
      bus.out_rd_we    <= 1'b0;
      bus.out_rd_addr  <= '0;
      bus.out_is_load  <= 1'b0;
      bus.out_illegal  <= 1'b0;
    end else if (bus.flush) begin
      state_q       <= EMPTY;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      state_q          <= FULL;
      bus.out_valid    <= 1'b1;
      bus.out_pc       <= bus.pc_i;
      bus.out_opcode   <= opc;
      bus.out_funct3   <= ins[14:12];
      bus.out_funct7   <= ins[31:25];
      bus.out_imm      <= imm;
      bus.out_rs1_data <= bus.rs1_data_i;
      bus.out_rs2_data <= bus.rs2_data_i;
      bus.out_rd_we    <= rd_en & (rd != 5'd0);
      bus.out_rd_addr  <= rd;
      bus.out_is_load  <= is_load;
      bus.out_illegal  <= illegal;
    end else if (state_q == FULL && bus.out_ready) begin
      state_q       <= hazard ? BUBBLE : EMPTY;
      bus.out_valid <= 1'b0;
    end else if (state_q == BUBBLE) begin
      state_q       <= EMPTY;
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plus randomized checks of id_stage against a behavioural decode/handshake model
module tb_id_stage;
  typedef struct packed {
    logic        rs1_re, rs2_re, rd_we, is_load, illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } dec_t;
  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] ins;
    dec_t        d;
    logic [31:0] d1, d2;
  } held_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] rf [32];
  int tests = 0;
  int failed = 0;
  logic m_valid;
  held_t m;
  logic last_rdy;
  id_stage_if #(.PC_WIDTH(10)) bus ();
  id_stage #(.PC_WIDTH(10), .HAZARD_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.rs1_data_i = rf[bus.rs1_addr];
  assign bus.rs2_data_i = rf[bus.rs2_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    byte f;
    logic wr;
    int v;
    d = '0;
    case (i[6:0])
      7'h37, 7'h17:        f = "U";
      7'h6F:               f = "J";
      7'h67, 7'h03, 7'h13: f = "I";
      7'h63:               f = "B";
      7'h23:               f = "S";
      7'h33:               f = "R";
      default:             f = "X";
    endcase
    d.illegal = (f == "X");
    d.is_load = (i[6:0] == 7'h03);
    d.rs1_re  = f inside {"I", "S", "B", "R"};
    d.rs2_re  = f inside {"S", "B", "R"};
    wr        = f inside {"U", "J", "I", "R"};
    d.rs1     = d.rs1_re ? i[19:15] : 5'd0;
    d.rs2     = d.rs2_re ? i[24:20] : 5'd0;
    d.rd      = wr ? i[11:7] : 5'd0;
    d.rd_we   = wr && (i[11:7] != 5'd0);
    v = 0;
    case (f)
      "I": v = (i[6:0] == 7'h13 && i[14:12] inside {3'd1, 3'd5}) ? int'(i[24:20]) : int'($signed(i[31:20]));
      "S": v = $signed({i[31:25], i[11:7]});
      "B": v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      "U": v = int'(i & 32'hFFFF_F000);
      "J": v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      default: v = 0;
    endcase
    d.imm = v;
    return d;
  endfunction

  task automatic check_out();
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", bus.out_pc, m.pc);
      chk("out_opcode", bus.out_opcode, m.ins[6:0]);
      chk("out_funct3", bus.out_funct3, m.ins[14:12]);
      chk("out_funct7", bus.out_funct7, m.ins[31:25]);
      chk("out_imm", bus.out_imm, m.d.imm);
      chk("out_rs1_data", bus.out_rs1_data, m.d1);
      chk("out_rs2_data", bus.out_rs2_data, m.d2);
      chk("out_rd_we", bus.out_rd_we, m.d.rd_we);
      chk("out_rd_addr", bus.out_rd_addr, m.d.rd);
      chk("out_is_load", bus.out_is_load, m.d.is_load);
      chk("out_illegal", bus.out_illegal, m.d.illegal);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [9:0] pc,
                      input logic ordy, input logic fl);
    dec_t d;
    logic hz, rdy;
    bus.in_valid = iv; bus.inst = ins; bus.pc_i = pc; bus.out_ready = ordy; bus.flush = fl;
    #1;
    d   = ref_decode(ins);
    hz  = m_valid && m.d.is_load && m.d.rd_we && iv &&
          ((d.rs1_re && d.rs1 == m.d.rd) || (d.rs2_re && d.rs2 == m.d.rd));
    rdy = !fl && !hz && (!m_valid || ordy);
    chk("in_ready", bus.in_ready, rdy);
    chk("rs1_re", bus.rs1_re, d.rs1_re);
    chk("rs2_re", bus.rs2_re, d.rs2_re);
    chk("rs1_addr", bus.rs1_addr, d.rs1);
    chk("rs2_addr", bus.rs2_addr, d.rs2);
    last_rdy = bus.in_ready;
    if (fl) m_valid = 1'b0;
    else if (iv && rdy) begin
      m_valid = 1'b1;
      m.pc = pc; m.ins = ins; m.d = d; m.d1 = rf[d.rs1]; m.d2 = rf[d.rs2];
    end else if (ordy) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_pc"}, bus.out_pc, 0);
    chk({tag, "_imm"}, bus.out_imm, 0);
    chk({tag, "_rs1_data"}, bus.out_rs1_data, 0);
    chk({tag, "_rd_we"}, bus.out_rd_we, 0);
    chk({tag, "_rd_addr"}, bus.out_rd_addr, 0);
    chk({tag, "_is_load"}, bus.out_is_load, 0);
    chk({tag, "_illegal"}, bus.out_illegal, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [31:0] i;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h7F};
    i = $urandom;
    i[6:0]   = (($urandom_range(0, 3) == 0) ? 7'h03 : ops[$urandom_range(0, 9)]);
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    rf[0] = 32'd0;
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    m_valid = 1'b0;
    m = '0;
    last_rdy = 1'b0;
    bus.in_valid = 1'b0; bus.inst = 32'h0000_0013; bus.pc_i = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    step(1'b1, 32'hFFF3_0293, 10'h004, 1'b1, 1'b0);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
    chk("addi_rd", bus.out_rd_addr, 5);
    step(1'b1, 32'hFE20_AE23, 10'h008, 1'b1, 1'b0);
    chk("sw_imm", bus.out_imm, 32'hFFFF_FFFC);
    chk("sw_rd_we", bus.out_rd_we, 0);
    step(1'b1, 32'h0000_A183, 10'h00C, 1'b1, 1'b0);
    chk("lw_is_load", bus.out_is_load, 1);
    step(1'b1, 32'h0021_8233, 10'h010, 1'b1, 1'b0);
    chk("hazard_in_ready", last_rdy, 0);
    chk("bubble_valid", bus.out_valid, 0);
    step(1'b1, 32'h0021_8233, 10'h010, 1'b1, 1'b0);
    chk("add_accept", last_rdy, 1);
    chk("add_rd", bus.out_rd_addr, 4);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h0052_0393, 10'h014, 1'b0, 1'b0);
      chk("hold_in_ready", last_rdy, 0);
      chk("hold_pc", bus.out_pc, 10'h010);
    end
    step(1'b1, 32'h0052_0393, 10'h014, 1'b1, 1'b0);
    chk("release_accept", last_rdy, 1);
    chk("release_pc", bus.out_pc, 10'h014);
    step(1'b1, 32'hFE20_AE23, 10'h018, 1'b1, 1'b1);
    chk("flush_in_ready", last_rdy, 0);
    chk("flush_valid", bus.out_valid, 0);
    step(1'b1, 32'h0000_007F, 10'h01C, 1'b1, 1'b0);
    chk("ill_flag", bus.out_illegal, 1);
    chk("ill_imm", bus.out_imm, 0);
    chk("ill_rd_we", bus.out_rd_we, 0);
    step(1'b1, 32'h0000_0013, 10'h020, 1'b1, 1'b0);
    chk("nop_rd_we", bus.out_rd_we, 0);
    chk("nop_valid", bus.out_valid, 1);
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) != 0, rand_inst(), 10'($urandom_range(0, 1023)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    step(1'b1, 32'hFFF3_0293, 10'h3F0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    m_valid = 1'b0;
    m = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 32'hFFF3_0293, 10'h004, 1'b1, 1'b0);
    chk("post_rst_valid", bus.out_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, width of all PC ports.
REQ-002 SHALL have parameter HAZARD_EN, default 1, enabling load-use stall insertion (0 = never stall).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1  upstream handshake for the fetched instruction.
REQ-006 SHALL have ports pc_i input PC_WIDTH and inst input 32  fetched PC and instruction.
REQ-007 SHALL have ports rs1_re, rs2_re output 1 and rs1_addr, rs2_addr output 5  combinational regfile read requests.
REQ-008 SHALL have ports rs1_data_i, rs2_data_i input 32  combinational regfile read data.
REQ-009 SHALL have port flush input 1  synchronous kill of the held and incoming instruction.
REQ-010 SHALL have ports out_valid output 1 / out_ready input 1  downstream (EX) handshake.
REQ-011 SHALL have registered outputs out_pc PC_WIDTH, out_opcode 7, out_funct3 3, out_funct7 7, out_imm 32, out_rs1_data 32, out_rs2_data 32, out_rd_we 1, out_rd_addr 5, out_is_load 1, out_illegal 1.

Function
REQ-012 SHALL decode inst combinationally: rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7]; address outputs SHALL be 0 when the matching enable is 0.
REQ-013 SHALL set enables per opcode: LUI/AUIPC/JAL rd; JALR/LOAD/OP-IMM rs1+rd; BRANCH/STORE rs1+rs2; OP rs1+rs2+rd; any other opcode none, with illegal = 1.
REQ-014 SHALL form imm sign-extended from inst[31]: I {inst[31:20]}, S {inst[31:25],inst[11:7]}, B {inst[31],inst[7],inst[30:25],inst[11:8],0}, U {inst[31:12],12'b0}, J {inst[31],inst[19:12],inst[20],inst[30:21],0}; SLLI/SRLI/SRAI imm = zero-extended inst[24:20]; R-type and illegal imm = 0.
REQ-015 SHALL force rd_we = 0 when rd = 0.
REQ-016 SHALL implement a three-state FSM: EMPTY (out_valid=0), FULL (out_valid=1), BUBBLE (out_valid=0, one-cycle stall after load-use).
REQ-017 SHALL compute hazard = HAZARD_EN & out_valid & out_is_load & out_rd_we & in_valid & ((rs1_re & rs1_addr==out_rd_addr) | (rs2_re & rs2_addr==out_rd_addr)).
REQ-018 SHALL drive in_ready = !flush & !hazard & (!out_valid | out_ready).
REQ-019 SHALL, on in_valid & in_ready, capture all decoded fields plus rs1_data_i/rs2_data_i into the output register; latency 1 cycle, throughput 1 per cycle.
REQ-020 SHALL, on hazard & out_ready, go to BUBBLE (out_valid=0) for exactly one cycle, then accept the stalled instruction normally.
REQ-021 SHALL, in FULL with out_ready=0, hold every output stable.
REQ-022 SHALL, on FULL & out_ready & no new accept, go to EMPTY.
REQ-023 SHALL, on flush, go to EMPTY next cycle regardless of state or out_ready; flush has priority over accept and hazard.
REQ-024 SHALL pass illegal instructions downstream with out_illegal=1 and no register side effects.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state EMPTY, out_valid=0 and all registered outputs to 0.
REQ-026 SHALL accept the first instruction no earlier than the first rising edge after rst deasserts; reset mid-transfer SHALL drop the held instruction.

Verification
REQ-027 ADDI x5,x6,-1 (0xFFF30293), pc 0x004 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd_addr=5, rs1_addr=6 during accept.
REQ-028 SW x2,-4(x1) (0xFE20AE23) -> out_imm=0xFFFFFFFC, out_rd_we=0, rs1_addr=1, rs2_addr=2.
REQ-029 LW x3,0(x1) then ADD x4,x3,x2, out_ready=1 -> in_ready=0 one cycle, one out_valid=0 bubble, ADD issued next.
REQ-030 out_ready=0 for 3 cycles with FULL -> outputs unchanged, in_ready=0; release -> next instruction accepted same cycle.
REQ-031 flush=1 while FULL and in_valid=1 -> out_valid=0 next cycle, incoming instruction not accepted.
REQ-032 inst 0x0000007F -> out_illegal=1, all enables 0, out_imm=0; ADDI x0,x0,0 -> out_rd_we=0.
